// File: rtl/bshift_arb.sv
// Two-requester round-robin front end for an external 32-bit left barrel shifter.
// It registers one result per cycle and can optionally saturate results whose signed value was lost.
module bshift_arb #(
  parameter bit          SAT_EN = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shamt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shamt,
  output logic             req1_ready,
  output logic [31:0]      sh_din,
  output logic [4:0]       sh_ctrl,
  input  logic [31:0]      sh_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_id,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam logic [DW-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] SAT_NEG = 32'h8000_0000;

  logic                 last_grant;
  logic                 gnt_c;
  logic                 any_vld_c;
  logic                 accept_c;
  logic                 xfer_in_c;
  logic                 xfer_out_c;
  logic                 ovf_c;
  logic signed [DW-1:0] top_bits_c;
  logic [DW-1:0]        res_c;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    gnt_c = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_c = ~last_grant;
    end else if (req1_valid) begin
      gnt_c = 1'b1;
    end
  end

  assign any_vld_c  = req0_valid | req1_valid;
  assign accept_c   = ~out_valid | out_ready;
  assign req0_ready = ~rst & accept_c & req0_valid & ~gnt_c;
  assign req1_ready = ~rst & accept_c & req1_valid &  gnt_c;
  assign xfer_in_c  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign xfer_out_c = out_valid & out_ready;

  // Steer the granted operand to the shifter; idle inputs are forced to zero.
  always_comb begin
    sh_din  = '0;
    sh_ctrl = '0;
    if (any_vld_c) begin
      sh_din  = gnt_c ? req1_data  : req0_data;
      sh_ctrl = gnt_c ? req1_shamt : req0_shamt;
    end
  end

  // Arithmetic shift leaves only din[31:31-shamt]; they must all match to keep the sign.
  always_comb begin
    top_bits_c = $signed(sh_din) >>> (SW'(31) - sh_ctrl);
    ovf_c      = ~((top_bits_c == '0) | (top_bits_c == '1));
    res_c      = sh_dout;
    if (SAT_EN && ovf_c) begin
      res_c = sh_din[DW-1] ? SAT_NEG : SAT_POS;
    end
  end

  // Single output stage: load on input transfer, otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= 1'b0;
      out_ovf    <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer_in_c) begin
      out_valid  <= 1'b1;
      out_data   <= res_c;
      out_id     <= gnt_c;
      out_ovf    <= ovf_c;
      last_grant <= gnt_c;
    end else if (xfer_out_c) begin
      out_valid  <= 1'b0;
    end
  end

  // Overflow events are counted when the consumer takes them, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (xfer_out_c && out_ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
